// File: rtl/block_sweep_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : block_sweep_ctrl_pkg
//  Description : Shared types and constants for the logic-block sweep
//                controller (FSM states, vector geometry, bit positions).
//  Revision    : 1.0  initial release
// ============================================================================
package block_sweep_ctrl_pkg;

  // Sweep controller states
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    DRIVE = 3'd1,
    WAIT  = 3'd2,
    CHECK = 3'd3,
    DONE  = 3'd4
  } state_e;

  localparam int VEC_COUNT = 16;  // all {I0,I1,S0,S1} combinations
  localparam int ERR_W     = 5;   // holds 0..16 without wrapping
  localparam int IDX_W     = 4;   // vector index width
  localparam int CNT_W     = 4;   // settle counter width

  // Position of each block input inside a 4-bit test vector
  localparam int VB_I0 = 3;
  localparam int VB_I1 = 2;
  localparam int VB_S0 = 1;
  localparam int VB_S1 = 0;

endpackage : block_sweep_ctrl_pkg
`default_nettype wire

// File: rtl/block_sweep_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : block_sweep_ctrl_if
//  Description : Bundle of the sweep controller's start/result handshake and
//                the pins that drive/observe the 2-input/2-select block.
//  Revision    : 1.0  initial release
// ============================================================================
interface block_sweep_ctrl_if;
  import block_sweep_ctrl_pkg::*;

  logic             start;
  logic             dut_i0;
  logic             dut_i1;
  logic             dut_s0;
  logic             dut_s1;
  logic             dut_o0;
  logic             dut_o1;
  logic             busy;
  logic             done;
  logic             pass;
  logic [ERR_W-1:0] err_cnt;
  logic [IDX_W-1:0] first_fail;
  logic             first_fail_v;

  // Environment side: issues start, models the block outputs, reads results
  modport master (
    output start, dut_o0, dut_o1,
    input  dut_i0, dut_i1, dut_s0, dut_s1,
    input  busy, done, pass, err_cnt, first_fail, first_fail_v
  );

  // Controller side
  modport slave (
    input  start, dut_o0, dut_o1,
    output dut_i0, dut_i1, dut_s0, dut_s1,
    output busy, done, pass, err_cnt, first_fail, first_fail_v
  );

endinterface : block_sweep_ctrl_if
`default_nettype wire

// File: rtl/block_sweep_ctrl_golden.sv
`default_nettype none
// ============================================================================
//  Module      : block_golden_model
//  Description : Combinational reference of the 2-input/2-select logic block.
//                Produces the expected O0/O1 for one input combination.
//  Revision    : 1.0  initial release
// ============================================================================
module block_golden_model (
  input  logic i0_i,
  input  logic i1_i,
  input  logic s0_i,
  input  logic s1_i,
  output logic exp_o0_o,
  output logic exp_o1_o
);

  logic a_w;
  logic b_w;
  logic c_w;

  // Block transfer function
  always_comb begin
    a_w      = s1_i | i0_i;
    b_w      = s0_i & i1_i;
    c_w      = a_w ^ b_w;
    exp_o0_o = s0_i ? (a_w | b_w) : c_w;
    exp_o1_o = s1_i ? c_w : (a_w & b_w);
  end

endmodule : block_golden_model
`default_nettype wire

// File: rtl/block_sweep_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : block_sweep_ctrl
//  Description : BIST driver/checker for the 2-input/2-select logic block.
//                Walks all 16 input vectors, samples O0/O1 after a settle
//                time, and reports error count, first failing vector, pass.
//  Revision    : 1.0  initial release
// ============================================================================
module block_sweep_ctrl
  import block_sweep_ctrl_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2   // 0..15
) (
  input  logic               clk,
  input  logic               rst,
  block_sweep_ctrl_if.slave  bus
);

  localparam logic [IDX_W-1:0] IDX_LAST    = IDX_W'(VEC_COUNT - 1);
  // Only meaningful when SETTLE_CYCLES > 0; WAIT is skipped otherwise
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       vec_q, vec_d;
  logic [ERR_W-1:0] err_q, err_d;
  logic [IDX_W-1:0] ff_q, ff_d;
  logic             ffv_q, ffv_d;
  logic             pass_q, pass_d;

  logic             exp_o0_w;
  logic             exp_o1_w;
  logic             mismatch_w;

  // Expected response for the vector currently on the block pins
  block_golden_model u_golden (
    .i0_i     (vec_q[VB_I0]),
    .i1_i     (vec_q[VB_I1]),
    .s0_i     (vec_q[VB_S0]),
    .s1_i     (vec_q[VB_S1]),
    .exp_o0_o (exp_o0_w),
    .exp_o1_o (exp_o1_w)
  );

  // Case-equality so X/Z from the block is treated as a failure in simulation
  assign mismatch_w = (bus.dut_o0 !== exp_o0_w) | (bus.dut_o1 !== exp_o1_w);

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      vec_q   <= '0;
      err_q   <= '0;
      ff_q    <= '0;
      ffv_q   <= 1'b0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      vec_q   <= vec_d;
      err_q   <= err_d;
      ff_q    <= ff_d;
      ffv_q   <= ffv_d;
      pass_q  <= pass_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (bus.start) state_d = DRIVE;
      DRIVE:   state_d = (SETTLE_CYCLES == 0) ? CHECK : WAIT;
      WAIT:    if (cnt_q == SETTLE_LAST) state_d = CHECK;
      CHECK:   state_d = (idx_q == IDX_LAST) ? DONE : DRIVE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath next values: vector launch, settle count, result accumulation
  always_comb begin
    idx_d  = idx_q;
    cnt_d  = cnt_q;
    vec_d  = vec_q;
    err_d  = err_q;
    ff_d   = ff_q;
    ffv_d  = ffv_q;
    pass_d = pass_q;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          idx_d  = '0;
          err_d  = '0;
          ff_d   = '0;
          ffv_d  = 1'b0;
          pass_d = 1'b0;
        end
      end
      DRIVE: begin
        vec_d = idx_q;
        cnt_d = '0;
      end
      WAIT: cnt_d = cnt_q + CNT_W'(1);
      CHECK: begin
        // One count per failing vector regardless of how many bits differ
        if (mismatch_w) begin
          err_d = err_q + ERR_W'(1);
          if (!ffv_q) begin
            ff_d  = idx_q;
            ffv_d = 1'b1;
          end
        end
        // pass is registered on the way into DONE so it is valid with done
        if (idx_q == IDX_LAST) pass_d = (err_d == '0);
        else                   idx_d  = idx_q + IDX_W'(1);
      end
      default: ;
    endcase
  end

  // Outputs decoded from state and result registers
  always_comb begin
    bus.busy         = (state_q == DRIVE) || (state_q == WAIT) || (state_q == CHECK);
    bus.done         = (state_q == DONE);
    bus.pass         = pass_q;
    bus.err_cnt      = err_q;
    bus.first_fail   = ff_q;
    bus.first_fail_v = ffv_q;
    bus.dut_i0       = vec_q[VB_I0];
    bus.dut_i1       = vec_q[VB_I1];
    bus.dut_s0       = vec_q[VB_S0];
    bus.dut_s1       = vec_q[VB_S1];
  end

endmodule : block_sweep_ctrl
`default_nettype wire

// File: tb/tb_block_sweep_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_block_sweep_ctrl
//  Description : Self-checking bench for block_sweep_ctrl. Attaches a block
//                model with programmable faults and compares the reported
//                results against fault-mask arithmetic.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_block_sweep_ctrl;

  localparam int SET_A = 2;
  localparam int SET_B = 0;

  logic clk = 1'b0;
  logic rst = 1'b1;

  block_sweep_ctrl_if bus_a ();
  block_sweep_ctrl_if bus_b ();

  block_sweep_ctrl #(.SETTLE_CYCLES(SET_A)) u_dut_a (.clk(clk), .rst(rst), .bus(bus_a));
  block_sweep_ctrl #(.SETTLE_CYCLES(SET_B)) u_dut_b (.clk(clk), .rst(rst), .bus(bus_b));

  always #5 clk = ~clk;

  // Fault-free block: returns {o1, o0}
  function automatic logic [1:0] blk(input logic [3:0] v);
    logic i0, i1, s0, s1, a, b, c;
    i0 = v[3]; i1 = v[2]; s0 = v[1]; s1 = v[0];
    a = s1 | i0;
    b = s0 & i1;
    c = a ^ b;
    return {(s1 ? c : (a & b)), (s0 ? (a | b) : c)};
  endfunction

  // Fault configuration of each attached block
  logic        st0_a = 1'b0, st1_a = 1'b0, st0_b = 1'b0, st1_b = 1'b0;
  logic [15:0] f0_a = '0, f1_a = '0, f0_b = '0, f1_b = '0;

  logic [3:0] vec_a, vec_b;
  logic [1:0] good_a, good_b;
  assign vec_a  = {bus_a.dut_i0, bus_a.dut_i1, bus_a.dut_s0, bus_a.dut_s1};
  assign vec_b  = {bus_b.dut_i0, bus_b.dut_i1, bus_b.dut_s0, bus_b.dut_s1};
  assign good_a = blk(vec_a);
  assign good_b = blk(vec_b);
  assign bus_a.dut_o0 = st0_a ? 1'b0 : (good_a[0] ^ f0_a[vec_a]);
  assign bus_a.dut_o1 = st1_a ? 1'b0 : (good_a[1] ^ f1_a[vec_a]);
  assign bus_b.dut_o0 = st0_b ? 1'b0 : (good_b[0] ^ f0_b[vec_b]);
  assign bus_b.dut_o1 = st1_b ? 1'b0 : (good_b[1] ^ f1_b[vec_b]);

  typedef struct packed {
    logic       busy;
    logic       done;
    logic       pass;
    logic [4:0] err;
    logic [3:0] ff;
    logic       fv;
    logic [3:0] vec;
  } obs_t;

  function automatic obs_t obs(input int sel);
    if (sel == 0)
      return obs_t'({bus_a.busy, bus_a.done, bus_a.pass, bus_a.err_cnt,
                     bus_a.first_fail, bus_a.first_fail_v, vec_a});
    return obs_t'({bus_b.busy, bus_b.done, bus_b.pass, bus_b.err_cnt,
                   bus_b.first_fail, bus_b.first_fail_v, vec_b});
  endfunction

  task automatic set_start(input int sel, input logic v);
    if (sel == 0) bus_a.start = v;
    else          bus_b.start = v;
  endtask

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // One full sweep: start pulse, watch latency/busy/vector walk, check results
  task automatic sweep(input int sel, input string tag, input int e_err,
                       input int e_first, input bit e_fv, input bit poke);
    int   per, lat, busy_n, walk_bad;
    obs_t o;
    per      = ((sel == 0) ? SET_A : SET_B) + 2;
    lat      = -1;
    busy_n   = 0;
    walk_bad = 0;
    @(negedge clk); set_start(sel, 1'b1);
    @(negedge clk); set_start(sel, 1'b0);
    for (int cyc = 1; cyc <= 400 && lat < 0; cyc++) begin
      o = obs(sel);
      if (o.done) lat = cyc;
      else begin
        if (o.busy) busy_n++;
        if (cyc >= 2 && int'(o.vec) != (cyc - 2) / per) walk_bad++;
        if (poke) set_start(sel, (cyc >= 10 && cyc < 13));
        @(negedge clk);
      end
    end
    set_start(sel, 1'b0);
    o = obs(sel);
    chk({tag, "/latency"},  lat, 16 * per + 1);
    chk({tag, "/busy_cyc"}, busy_n, 16 * per);
    chk({tag, "/walk"},     walk_bad, 0);
    chk({tag, "/err_cnt"},  int'(o.err), e_err);
    chk({tag, "/first"},    int'(o.ff), e_first);
    chk({tag, "/first_v"},  int'(o.fv), int'(e_fv));
    chk({tag, "/pass"},     int'(o.pass), int'(e_err == 0));
    chk({tag, "/busy_done"}, int'(o.busy), 0);
    chk({tag, "/last_vec"}, int'(o.vec), 15);
    @(negedge clk);
    o = obs(sel);
    chk({tag, "/done_1cyc"}, int'(o.done), 0);
    chk({tag, "/err_hold"},  int'(o.err), e_err);
  endtask

  typedef struct {
    bit          st0;
    bit          st1;
    logic [15:0] f0;
    logic [15:0] f1;
    int          exp_err;
    int          exp_first;
    bit          exp_fv;
  } tv_t;

  tv_t tbl[12];

  initial begin
    int   found, dcount, d1, d2, low;
    obs_t o;

    bus_a.start = 1'b0;
    bus_b.start = 1'b0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_a", int'(obs(0)), 0);
    chk("reset_b", int'(obs(1)), 0);
    rst = 1'b0;

    // Directed records: fault-free, stuck outputs, first/last-vector and max-count boundaries
    tbl[0] = '{1'b0, 1'b0, 16'h0000, 16'h0000,  0,  0, 1'b0};
    tbl[1] = '{1'b0, 1'b1, 16'h0000, 16'h0000,  7,  1, 1'b1};
    tbl[2] = '{1'b1, 1'b0, 16'h0000, 16'h0000, 13,  1, 1'b1};
    tbl[3] = '{1'b0, 1'b0, 16'h8000, 16'h0000,  1, 15, 1'b1};
    tbl[4] = '{1'b0, 1'b0, 16'h0001, 16'h0001,  1,  0, 1'b1};
    tbl[5] = '{1'b0, 1'b0, 16'hFFFF, 16'h0000, 16,  0, 1'b1};
    // Random fault masks: expectation is the set of corrupted vectors
    for (int i = 6; i < 12; i++) begin
      logic [15:0] m0, m1, m;
      int e, f;
      m0 = 16'($urandom & $urandom);
      m1 = 16'($urandom & $urandom & $urandom);
      m  = m0 | m1;
      e  = 0;
      f  = -1;
      for (int b = 0; b < 16; b++) if (m[b]) begin e++; if (f < 0) f = b; end
      tbl[i] = '{1'b0, 1'b0, m0, m1, e, ((f < 0) ? 0 : f), (f >= 0)};
    end

    for (int i = 0; i < 12; i++) begin
      st0_a = tbl[i].st0; st1_a = tbl[i].st1;
      f0_a  = tbl[i].f0;  f1_a  = tbl[i].f1;
      repeat ($urandom_range(0, 3)) @(negedge clk);
      sweep(0, $sformatf("vec%0d", i), tbl[i].exp_err, tbl[i].exp_first,
            tbl[i].exp_fv, ($urandom_range(0, 1) == 1));
    end

    // Reset during WAIT of vector 6 aborts with results cleared and no done
    st0_a = 1'b0; st1_a = 1'b1; f0_a = '0; f1_a = '0;
    @(negedge clk); bus_a.start = 1'b1;
    @(negedge clk); bus_a.start = 1'b0;
    found = 0;
    for (int cyc = 0; cyc < 100 && found == 0; cyc++) begin
      if (bus_a.busy && vec_a == 4'd6) found = 1;
      else @(negedge clk);
    end
    chk("rst/reach_idx6", found, 1);
    chk("rst/pre_err", int'(bus_a.err_cnt), 3);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst/cleared", int'(obs(0)), 0);
    dcount = 0;
    for (int cyc = 0; cyc < 80; cyc++) begin
      @(negedge clk);
      if (bus_a.done || bus_a.busy) dcount++;
    end
    chk("rst/no_activity", dcount, 0);
    st1_a = 1'b0;
    sweep(0, "after_rst", 0, 0, 1'b0, 1'b0);

    // start held high: back-to-back sweeps with one idle cycle between
    d1 = -1; d2 = -1; low = 0;
    @(negedge clk); bus_a.start = 1'b1;
    for (int cyc = 0; cyc < 400 && d2 < 0; cyc++) begin
      @(negedge clk);
      if (bus_a.done) begin
        if (d1 < 0) d1 = cyc;
        else        d2 = cyc;
      end
      if (d1 >= 0 && d2 < 0 && !bus_a.busy) low++;
    end
    bus_a.start = 1'b0;
    o = obs(0);
    chk("held/done_gap", d2 - d1, 66);
    chk("held/busy_low", low, 2);
    chk("held/err_cnt", int'(o.err), 0);
    chk("held/pass", int'(o.pass), 1);
    @(negedge clk);
    @(negedge clk);
    chk("held/idle_after", int'(bus_a.busy), 0);

    // Zero settle time instance
    sweep(1, "s0_clean", 0, 0, 1'b0, 1'b0);
    st1_b = 1'b1;
    sweep(1, "s0_o1stuck", 7, 1, 1'b1, 1'b1);
    st1_b = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_block_sweep_ctrl
`default_nettype wire
